scroll_display: RTL and testbench

Parametrised scrolling buffer for the multi-digit seven-segment display path. It captures a message of MSG_NIBBLES hex nibbles on the falling edge of a load strobe. It rotates the message one nibble per step, left or right, in continuous or single-pass mode, with pause. The leftmost DIGITS nibbles are presented on dataBus to the digit-scan/decoder stage.

---
 rtl/scroll_pkg.sv | 26 ++
 rtl/scroll_display_fall_edge_det.sv | 23 ++
 rtl/scroll_display.sv | 121 ++++++++++++
 tb/tb_scroll_display.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/scroll_pkg.sv
// Shared constants and helpers for the scrolling display path.
package scroll_pkg;

    // Rotation direction encodings
    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

    // Scroll mode encodings
    localparam logic MODE_CONT   = 1'b0;
    localparam logic MODE_SINGLE = 1'b1;

    // Width needed to hold a rotation offset 0..n-1; at least one bit.
    function automatic int pos_width(input int n);
        int w;
        w = 1;
        for (int k = 1; k < 31; k++) begin
            if ((32'sd1 <<< k) < n) begin
                w = k + 1;
            end else begin
                w = w;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/scroll_display_fall_edge_det.sv
// One-flop falling-edge detector with synchronous active-low clear.
// o_fall is high during the cycle in which i_strobe is sampled low after high.
module fall_edge_det (
    input  logic i_clk,
    input  logic i_clr_n,
    input  logic i_strobe,
    output logic o_fall
);

    logic r_prev;

    // Remember the strobe level seen at the previous edge
    always_ff @(posedge i_clk) begin
        if (!i_clr_n) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= i_strobe;
        end
    end

    assign o_fall = r_prev & ~i_strobe;

endmodule

// File: rtl/scroll_display.sv
// Scrolling message buffer for the seven-segment display path. Loads a
// message on the falling edge of the load strobe and rotates it one nibble
// per clock, presenting the leftmost DIGITS nibbles on dataBus.
module scroll_display
    import scroll_pkg::*;
#(
    parameter  int DIGITS      = 4,
    parameter  int MSG_NIBBLES = 8,
    parameter  int NIB_W       = 4,
    localparam int POS_W       = pos_width(MSG_NIBBLES)
) (
    input  logic                          clk3hz,
    input  logic                          clr,
    input  logic                          disp_data_en,
    input  logic [MSG_NIBBLES*NIB_W-1:0]  datain,
    input  logic                          dir,
    input  logic                          mode,
    input  logic                          pause,
    output logic [DIGITS*NIB_W-1:0]       dataBus,
    output logic [POS_W-1:0]              pos,
    output logic                          busy,
    output logic                          done
);

    localparam int               MSG_W   = MSG_NIBBLES * NIB_W;
    localparam int               WIN_W   = DIGITS * NIB_W;
    localparam logic [POS_W-1:0] POS_MAX = POS_W'(MSG_NIBBLES - 1);
    localparam logic [POS_W-1:0] POS_ONE = POS_W'(1'b1);
    localparam logic [POS_W-1:0] POS_ZERO = {POS_W{1'b0}};

    // Refuse to build with a window wider than the message or a degenerate message
    generate
        if ((DIGITS > MSG_NIBBLES) || (MSG_NIBBLES < 2) || (DIGITS < 1)) begin : g_param_check
            $error("scroll_display: illegal DIGITS/MSG_NIBBLES combination");
        end
    endgenerate

    logic [MSG_W-1:0] r_msg;
    logic [POS_W-1:0] r_pos;
    logic             r_busy;
    logic             r_done;

    logic             w_load;
    logic [MSG_W-1:0] w_msg_nx;
    logic [POS_W-1:0] w_pos_nx;
    logic [POS_W-1:0] w_pos_step;
    logic             w_busy_nx;
    logic             w_done_nx;

    fall_edge_det u_load_det (
        .i_clk    (clk3hz),
        .i_clr_n  (clr),
        .i_strobe (disp_data_en),
        .o_fall   (w_load)
    );

    // Next rotation offset for one step; wrap is explicit for odd lengths
    always_comb begin
        w_pos_step = r_pos;
        if (dir == DIR_LEFT) begin
            w_pos_step = (r_pos == POS_ZERO) ? POS_MAX : (r_pos - POS_ONE);
        end else begin
            w_pos_step = (r_pos == POS_MAX) ? POS_ZERO : (r_pos + POS_ONE);
        end
    end

    // Next-state: load beats pause, pause beats done-hold, done-hold beats step
    always_comb begin
        w_msg_nx  = r_msg;
        w_pos_nx  = r_pos;
        w_busy_nx = r_busy;
        w_done_nx = r_done;
        if (w_load) begin
            w_msg_nx  = datain;
            w_pos_nx  = POS_ZERO;
            w_busy_nx = 1'b1;
            w_done_nx = 1'b0;
        end else if (pause) begin
            w_msg_nx = r_msg;
        end else if (r_done) begin
            w_msg_nx = r_msg;
        end else if (r_busy) begin
            if (dir == DIR_LEFT) begin
                w_msg_nx = {r_msg[MSG_W-NIB_W-1:0], r_msg[MSG_W-1 -: NIB_W]};
            end else begin
                w_msg_nx = {r_msg[NIB_W-1:0], r_msg[MSG_W-1:NIB_W]};
            end
            w_pos_nx = w_pos_step;
            // A single pass ends the moment the offset comes back to the loaded alignment
            if ((mode == MODE_SINGLE) && (w_pos_step == POS_ZERO)) begin
                w_done_nx = 1'b1;
                w_busy_nx = 1'b0;
            end else begin
                w_done_nx = 1'b0;
            end
        end else begin
            w_msg_nx = r_msg;
        end
    end

    // State registers with synchronous active-low clear taking top priority
    always_ff @(posedge clk3hz) begin
        if (!clr) begin
            r_msg  <= {MSG_W{1'b0}};
            r_pos  <= POS_ZERO;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_msg  <= w_msg_nx;
            r_pos  <= w_pos_nx;
            r_busy <= w_busy_nx;
            r_done <= w_done_nx;
        end
    end

    assign dataBus = r_msg[MSG_W-1 -: WIN_W];
    assign pos     = r_pos;
    assign busy    = r_busy;
    assign done    = r_done;

endmodule

// File: tb/tb_scroll_display.sv
// Directed bench for scroll_display: an 8-nibble/4-digit instance and a
// 5-nibble/3-digit instance sharing clock, reset and control inputs.
module tb_scroll_display;

    logic        clk3hz = 1'b0;
    logic        clr = 1'b0;
    logic        dir = 1'b0;
    logic        mode = 1'b0;
    logic        pause = 1'b0;

    logic        en_m = 1'b0;
    logic [31:0] datain_m = 32'h0;
    logic [15:0] bus_m;
    logic [2:0]  pos_m;
    logic        busy_m;
    logic        done_m;

    logic        en_o = 1'b0;
    logic [19:0] datain_o = 20'h0;
    logic [11:0] bus_o;
    logic [2:0]  pos_o;
    logic        busy_o;
    logic        done_o;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk3hz = ~clk3hz;

    scroll_display #(.DIGITS(4), .MSG_NIBBLES(8), .NIB_W(4)) u_main (
        .clk3hz(clk3hz), .clr(clr), .disp_data_en(en_m), .datain(datain_m),
        .dir(dir), .mode(mode), .pause(pause),
        .dataBus(bus_m), .pos(pos_m), .busy(busy_m), .done(done_m)
    );

    scroll_display #(.DIGITS(3), .MSG_NIBBLES(5), .NIB_W(4)) u_odd (
        .clk3hz(clk3hz), .clr(clr), .disp_data_en(en_o), .datain(datain_o),
        .dir(dir), .mode(mode), .pause(pause),
        .dataBus(bus_o), .pos(pos_o), .busy(busy_o), .done(done_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk3hz);
    endtask

    task automatic chk_main(input string tag, input logic [15:0] bus, input logic [2:0] p,
                            input logic b, input logic d);
        check({tag, ".bus"},  32'(bus_m),  32'(bus));
        check({tag, ".pos"},  32'(pos_m),  32'(p));
        check({tag, ".busy"}, 32'(busy_m), 32'(b));
        check({tag, ".done"}, 32'(done_m), 32'(d));
    endtask

    task automatic load_main(input logic [31:0] data);
        datain_m = data;
        en_m = 1'b1;
        tick(1);
        en_m = 1'b0;
        tick(1);
    endtask

    initial begin
        // Reset
        tick(2);
        chk_main("reset", 16'h0000, 3'd0, 1'b0, 1'b0);
        check("reset_odd.bus", 32'(bus_o), 32'h0);
        clr = 1'b1;
        tick(3);
        chk_main("idle", 16'h0000, 3'd0, 1'b0, 1'b0);

        // Load and rotate right, continuous
        load_main(32'h41823205);
        chk_main("load_r", 16'h4182, 3'd0, 1'b1, 1'b0);
        tick(1);
        chk_main("step_r1", 16'h5418, 3'd1, 1'b1, 1'b0);
        // Strobe held high keeps stepping, no reload
        en_m = 1'b1;
        tick(2);
        chk_main("held_hi", 16'h2054, 3'd3, 1'b1, 1'b0);
        en_m = 1'b0;
        tick(1);
        chk_main("reload", 16'h4182, 3'd0, 1'b1, 1'b0);

        // Rotate left
        dir = 1'b1;
        load_main(32'h41823205);
        chk_main("load_l", 16'h4182, 3'd0, 1'b1, 1'b0);
        tick(1);
        chk_main("step_l1", 16'h1823, 3'd7, 1'b1, 1'b0);

        // Single pass
        dir = 1'b0;
        mode = 1'b1;
        load_main(32'h41823205);
        tick(7);
        chk_main("sp_7", 16'h1823, 3'd7, 1'b1, 1'b0);
        tick(1);
        chk_main("sp_done", 16'h4182, 3'd0, 1'b0, 1'b1);
        tick(10);
        chk_main("sp_hold", 16'h4182, 3'd0, 1'b0, 1'b1);
        mode = 1'b0;
        tick(2);
        chk_main("sp_mode0", 16'h4182, 3'd0, 1'b0, 1'b1);
        load_main(32'h41823205);
        chk_main("sp_reload", 16'h4182, 3'd0, 1'b1, 1'b0);

        // Pause (continuous, right)
        tick(2);
        chk_main("pz_2", 16'h0541, 3'd2, 1'b1, 1'b0);
        pause = 1'b1;
        tick(5);
        chk_main("pz_hold", 16'h0541, 3'd2, 1'b1, 1'b0);
        pause = 1'b0;
        tick(1);
        chk_main("pz_resume", 16'h2054, 3'd3, 1'b1, 1'b0);
        // Load accepted while paused
        pause = 1'b1;
        load_main(32'h41823205);
        chk_main("pz_load", 16'h4182, 3'd0, 1'b1, 1'b0);
        pause = 1'b0;

        // Reset mid-scroll, coincident with a strobe fall
        tick(2);
        en_m = 1'b1;
        tick(1);
        en_m = 1'b0;
        clr = 1'b0;
        tick(1);
        chk_main("rst_mid", 16'h0000, 3'd0, 1'b0, 1'b0);
        clr = 1'b1;
        tick(3);
        chk_main("rst_noload", 16'h0000, 3'd0, 1'b0, 1'b0);

        // Odd length, single pass
        mode = 1'b1;
        dir = 1'b0;
        datain_o = 20'hABCDE;
        en_o = 1'b1;
        tick(1);
        en_o = 1'b0;
        tick(1);
        check("odd_load.bus", 32'(bus_o), 32'h00000ABC);
        check("odd_load.pos", 32'(pos_o), 32'd0);
        tick(1); check("odd_p1", 32'(pos_o), 32'd1);
        check("odd_p1.bus", 32'(bus_o), 32'h00000EAB);
        tick(1); check("odd_p2", 32'(pos_o), 32'd2);
        tick(1); check("odd_p3", 32'(pos_o), 32'd3);
        tick(1); check("odd_p4", 32'(pos_o), 32'd4);
        check("odd_p4.done", 32'(done_o), 32'd0);
        tick(1); check("odd_p0", 32'(pos_o), 32'd0);
        check("odd_done", 32'(done_o), 32'd1);
        check("odd_busy", 32'(busy_o), 32'd0);
        check("odd_end.bus", 32'(bus_o), 32'h00000ABC);

        // Odd length, left wrap 0 -> 4
        dir = 1'b1;
        en_o = 1'b1;
        tick(1);
        en_o = 1'b0;
        tick(2);
        check("odd_l.pos", 32'(pos_o), 32'd4);
        check("odd_l.bus", 32'(bus_o), 32'h00000BCD);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
